exu_csr_seq: RTL and testbench

- Sequential, parametrised CSR execution unit in the EXU. Accepts one CSR instruction at a time over a valid/ready handshake.
- Performs a variable-latency read of the CSR file, computes the RW/RS/RC result and issues a single-cycle CSR write pulse.
- Returns the old CSR value to the register writeback port over a valid/ready handshake.
- Supports immediate forms, RISC-V side-effect suppression (no read when rd=x0 for RW; no write when the source is zero for RS/RC), interrupt abort and a read timeout.

---
 rtl/exu_csr_seq_pkg.sv | 39 +++
 rtl/csr_alu_comb.sv | 27 ++
 rtl/exu_csr_seq.sv | 201 ++++++++++++++++++++
 tb/tb_exu_csr_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_csr_seq_pkg.sv
// exu_csr_seq_pkg -- shared definitions for the sequential CSR execution unit.
//   csr_op_e    : CSR operation encoding carried on req_op_i (00 = RS without write)
//   csr_state_e : sequencer state encoding
//   INT_ASSERT  : active level of the interrupt-abort input
//   csr_writes  : decides whether an op is allowed to write the CSR
package exu_csr_seq_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_DRAIN,
    ST_WRITE,
    ST_WB
  } csr_state_e;

  localparam logic INT_ASSERT = 1'b1;

  // RISC-V side-effect rule: RS/RC only write when the source operand is
  // architecturally nonzero (register index or immediate, not the value).
  function automatic logic csr_writes(input csr_op_e    op,
                                      input logic       imm,
                                      input logic [4:0] zimm,
                                      input logic [4:0] rs1_idx);
    case (op)
      CSR_OP_RW:   return 1'b1;
      CSR_OP_NONE: return 1'b0;
      default:     return imm ? (zimm != 5'd0) : (rs1_idx != 5'd0);
    endcase
  endfunction

endpackage

// File: rtl/csr_alu_comb.sv
// csr_alu_comb -- combinational CSR data function, shared with the
// combinational CSR path.
//   op_i    : CSR operation (RW / RS / RC; NONE behaves as RS)
//   old_i   : current CSR value
//   src_i   : source operand (rs1 value or zero-extended immediate)
//   wdata_o : new CSR value
module csr_alu_comb
  import exu_csr_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  csr_op_e         op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] src_i,
  output logic [XLEN-1:0] wdata_o
);

  always_comb begin
    wdata_o = old_i | src_i;
    case (op_i)
      CSR_OP_RW: wdata_o = src_i;
      CSR_OP_RC: wdata_o = old_i & ~src_i;
      default:   wdata_o = old_i | src_i;
    endcase
  end

endmodule

// File: rtl/exu_csr_seq.sv
// exu_csr_seq -- sequential CSR execution unit (one instruction in flight).
// Optional build macro: CSR_RO_CHECK_EN (reject writes to addr[11:10]==2'b11).
//   req_*      : instruction handshake and operands
//   csr_rreq_o / csr_raddr_o / csr_rvalid_i / csr_rdata_i : CSR read port
//   csr_we_o / csr_waddr_o / csr_wdata_o                  : CSR write pulse
//   wb_*       : old-value writeback handshake
//   int_assert_i : abort an uncommitted op (effective in IDLE and WAIT)
//   busy_o     : sequencer not idle
//   err_o      : one-cycle pulse on read timeout or rejected write
module exu_csr_seq
  import exu_csr_seq_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CSR_AW     = 12,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic              req_imm_i,
  input  logic [XLEN-1:0]   req_src_i,
  input  logic [4:0]        req_zimm_i,
  input  logic [4:0]        req_rs1_idx_i,
  input  logic [4:0]        req_rd_i,
  input  logic [CSR_AW-1:0] req_addr_i,
  output logic              csr_rreq_o,
  output logic [CSR_AW-1:0] csr_raddr_o,
  input  logic              csr_rvalid_i,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  input  logic              int_assert_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned CntW = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

  csr_state_e        state_q;
  csr_op_e           op_q;
  logic [XLEN-1:0]   src_q;
  logic [XLEN-1:0]   old_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic [CSR_AW-1:0] addr_q;
  logic              we_en_q;
  logic [CntW-1:0]   cnt_q;
  logic              resp_seen_q;
  logic              rreq_q;
  logic              we_q;
  logic              err_q;
  logic              wb_valid_q;

  csr_op_e         op_d;
  logic [XLEN-1:0] src_d;
  logic            skip_rd_d;
  logic            we_en_d;
  logic            accept;
  logic            abort;
  logic            timeout;
  logic            ro_now;
  logic            ro_wait;
  logic [XLEN-1:0] alu_wdata;

  always_comb begin
    op_d      = csr_op_e'(req_op_i);
    src_d     = req_imm_i ? {{(XLEN-5){1'b0}}, req_zimm_i} : req_src_i;
    skip_rd_d = (op_d == CSR_OP_RW) && (req_rd_i == 5'd0);
    we_en_d   = csr_writes(op_d, req_imm_i, req_zimm_i, req_rs1_idx_i);
    abort     = (int_assert_i == INT_ASSERT);
    accept    = req_valid_i && req_ready_o;
    timeout   = (cnt_q == CntW'(RD_TIMEOUT - 1));
`ifdef CSR_RO_CHECK_EN
    // Skip path enters WRITE straight from IDLE, so it checks the incoming address.
    ro_now    = we_en_d && (req_addr_i[11:10] == 2'b11);
    ro_wait   = we_en_q && (addr_q[11:10] == 2'b11);
`else
    ro_now    = 1'b0;
    ro_wait   = 1'b0;
`endif
  end

  csr_alu_comb #(
    .XLEN(XLEN)
  ) u_alu (
    .op_i   (op_q),
    .old_i  (csr_rdata_i),
    .src_i  (src_q),
    .wdata_o(alu_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= CSR_OP_NONE;
      src_q       <= '0;
      old_q       <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      addr_q      <= '0;
      we_en_q     <= 1'b0;
      cnt_q       <= '0;
      resp_seen_q <= 1'b0;
      rreq_q      <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      rreq_q <= 1'b0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q        <= op_d;
            src_q       <= src_d;
            rd_q        <= req_rd_i;
            addr_q      <= req_addr_i;
            we_en_q     <= we_en_d;
            cnt_q       <= '0;
            resp_seen_q <= 1'b0;
            old_q       <= '0;
            if (skip_rd_d) begin
              // Only RW skips the read, so the write data is the source itself.
              state_q <= ST_WRITE;
              wdata_q <= src_d;
              we_q    <= we_en_d && !ro_now;
              err_q   <= ro_now;
            end else begin
              state_q <= ST_READ;
              rreq_q  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
        end
        ST_WAIT: begin
          if (abort) begin
            // A response arriving with the abort is already absorbed.
            state_q     <= ST_DRAIN;
            resp_seen_q <= csr_rvalid_i;
            if (!timeout) cnt_q <= cnt_q + 1'b1;
          end else if (csr_rvalid_i) begin
            state_q <= ST_WRITE;
            old_q   <= csr_rdata_i;
            wdata_q <= alu_wdata;
            we_q    <= we_en_q && !ro_wait;
            err_q   <= ro_wait;
          end else if (timeout) begin
            state_q <= ST_WRITE;
            old_q   <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (resp_seen_q || csr_rvalid_i || timeout) state_q <= ST_IDLE;
          else                                        cnt_q   <= cnt_q + 1'b1;
        end
        ST_WRITE: begin
          if (rd_q != 5'd0) begin
            state_q    <= ST_WB;
            wb_valid_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WB: begin
          if (wb_ready_i) begin
            wb_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) && !abort && !rst;
  assign busy_o      = (state_q != ST_IDLE);
  assign csr_rreq_o  = rreq_q;
  assign csr_raddr_o = addr_q;
  assign csr_we_o    = we_q;
  assign csr_waddr_o = addr_q;
  assign csr_wdata_o = wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = old_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_exu_csr_seq.sv
// tb_exu_csr_seq -- self-checking bench for exu_csr_seq with a transaction-level
// reference model and a randomized CSR responder. Honors CSR_RO_CHECK_EN.
module tb_exu_csr_seq;

  localparam int XLEN       = 32;
  localparam int CSR_AW     = 12;
  localparam int RD_TIMEOUT = 16;
`ifdef CSR_RO_CHECK_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic              req_imm;
  logic [XLEN-1:0]   req_src;
  logic [4:0]        req_zimm;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rd;
  logic [CSR_AW-1:0] req_addr;
  logic              csr_rreq;
  logic [CSR_AW-1:0] csr_raddr;
  logic              csr_rvalid;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_we;
  logic [CSR_AW-1:0] csr_waddr;
  logic [XLEN-1:0]   csr_wdata;
  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              int_assert;
  logic              busy;
  logic              err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exu_csr_seq #(
    .XLEN      (XLEN),
    .CSR_AW    (CSR_AW),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_imm_i    (req_imm),
    .req_src_i    (req_src),
    .req_zimm_i   (req_zimm),
    .req_rs1_idx_i(req_rs1),
    .req_rd_i     (req_rd),
    .req_addr_i   (req_addr),
    .csr_rreq_o   (csr_rreq),
    .csr_raddr_o  (csr_raddr),
    .csr_rvalid_i (csr_rvalid),
    .csr_rdata_i  (csr_rdata),
    .csr_we_o     (csr_we),
    .csr_waddr_o  (csr_waddr),
    .csr_wdata_o  (csr_wdata),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data),
    .int_assert_i (int_assert),
    .busy_o       (busy),
    .err_o        (err)
  );

  int n_checks;
  int n_fails;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction from the accept cycle (cycle 0) to the return to idle.
  // delay  : WAIT-cycle index at which rvalid is returned (>= RD_TIMEOUT: never)
  // int_at : WAIT-cycle index of a one-cycle interrupt pulse (-1: none)
  // stall  : cycles wb_ready is held low once wb_valid is seen
  task automatic run_op(input logic [1:0] op, input logic imm, input logic [31:0] src,
                        input logic [4:0] zimm, input logic [4:0] rs1, input logic [4:0] rd,
                        input logic [11:0] addr, input logic [31:0] csr_val,
                        input int delay, input int int_at, input int stall);
    logic [31:0] s, old, exp_wd;
    bit rd_en, wen, aborted, timed, ro, exp_we, exp_wb, done, wb_seen;
    int exp_err, exp_wcycle, n_rreq, n_we, n_err, stall_left;

    // Reference model from the architectural rules.
    s       = imm ? {27'd0, zimm} : src;
    rd_en   = !(op == 2'b01 && rd == 5'd0);
    wen     = (op == 2'b01) ? 1'b1 : (op == 2'b00) ? 1'b0 : (imm ? (zimm != 0) : (rs1 != 0));
    aborted = rd_en && (int_at >= 0);
    timed   = rd_en && !aborted && (delay >= RD_TIMEOUT);
    old     = (rd_en && !timed) ? csr_val : 32'd0;
    ro      = RO_EN && (addr[11:10] == 2'b11);
    exp_we  = !aborted && !timed && wen && !ro;
    case (op)
      2'b01:   exp_wd = s;
      2'b11:   exp_wd = old & ~s;
      default: exp_wd = old | s;
    endcase
    exp_err    = (!aborted && (timed || (wen && ro))) ? 1 : 0;
    exp_wb     = !aborted && (rd != 5'd0);
    exp_wcycle = rd_en ? (3 + (timed ? RD_TIMEOUT - 1 : delay)) : 1;

    req_valid = 1'b1; req_op = op; req_imm = imm; req_src = src; req_zimm = zimm;
    req_rs1 = rs1; req_rd = rd; req_addr = addr;
    check("req_ready", 64'(req_ready), 64'd1);

    n_rreq = 0; n_we = 0; n_err = 0; wb_seen = 0; done = 0; stall_left = stall;
    for (int c = 0; c < 80 && !done; c++) begin
      if (c > 0) req_valid = 1'b0;
      csr_rvalid = rd_en && (delay < RD_TIMEOUT) && (c == 2 + delay);
      csr_rdata  = csr_rvalid ? csr_val : $urandom;
      int_assert = (int_at >= 0) && (c == 2 + int_at);
      if (wb_valid) begin
        wb_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        wb_ready = 1'($urandom_range(0, 1));
      end
      if (c > 0) begin
        if (csr_rreq) begin
          n_rreq++;
          check("rreq_cycle", 64'(c), 64'd1);
          check("raddr", 64'(csr_raddr), 64'(addr));
        end
        if (csr_we) begin
          n_we++;
          check("we_cycle", 64'(c), 64'(exp_wcycle));
          check("waddr", 64'(csr_waddr), 64'(addr));
          check("wdata", 64'(csr_wdata), 64'(exp_wd));
        end
        if (err) begin
          n_err++;
          check("err_cycle", 64'(c), 64'(exp_wcycle));
        end
        if (wb_valid) begin
          if (!wb_seen) check("wb_cycle", 64'(c), 64'(exp_wcycle + 1));
          wb_seen = 1;
          check("wb_rd", 64'(wb_rd), 64'(rd));
          check("wb_data", 64'(wb_data), 64'(old));
        end
        if (!busy) begin
          done = 1;
          if (aborted) check("ready_after_drain", 64'(req_ready), 64'd1);
        end
      end
      if (!done) step();
    end
    csr_rvalid = 1'b0; int_assert = 1'b0; wb_ready = 1'b0;
    check("op_done", 64'(done), 64'd1);
    check("n_rreq", 64'(n_rreq), 64'(rd_en));
    check("n_we", 64'(n_we), 64'(exp_we));
    check("n_err", 64'(n_err), 64'(exp_err));
    check("wb_issued", 64'(wb_seen), 64'(exp_wb));
  endtask

  initial begin
    bit saw_bad;
    n_checks = 0; n_fails = 0;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_imm = 1'b0; req_src = '0;
    req_zimm = '0; req_rs1 = '0; req_rd = '0; req_addr = '0; csr_rvalid = 1'b0;
    csr_rdata = '0; wb_ready = 1'b0; int_assert = 1'b0;
    step(); step();

    // Reset state.
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pulses", 64'({csr_rreq, csr_we, wb_valid, err}), 64'd0);
    check("rst_data", 64'({csr_wdata, wb_data}), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(req_ready), 64'd1);
    step();

    // Reset in the middle of a read: no write and no writeback afterwards.
    req_valid = 1'b1; req_op = 2'b10; req_src = 32'h5; req_rs1 = 5'd2; req_rd = 5'd9;
    req_addr = 12'h305;
    step(); req_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    csr_rvalid = 1'b1; csr_rdata = 32'h1234;
    saw_bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      csr_rvalid = 1'b0;
      if (csr_we || wb_valid || busy) saw_bad = 1;
    end
    check("midrst_quiet", 64'(saw_bad), 64'd0);

    // Directed scenarios.
    run_op(2'b10, 1'b0, 32'h8, 5'd0, 5'd5, 5'd3, 12'h300, 32'h1800, 2, -1, 3);      // CSRRS
    run_op(2'b01, 1'b0, 32'hDEAD, 5'd0, 5'd1, 5'd0, 12'h340, 32'h77, 0, -1, 0);     // CSRRW rd=x0
    run_op(2'b11, 1'b1, 32'hFFFF, 5'd0, 5'd4, 5'd7, 12'h341, 32'hFF, 1, -1, 0);     // CSRRCI zimm=0
    run_op(2'b10, 1'b0, 32'h1, 5'd0, 5'd6, 5'd8, 12'h342, 32'h55, 3, 0, 0);         // abort, late rvalid
    run_op(2'b10, 1'b0, 32'h1, 5'd0, 5'd6, 5'd4, 12'h343, 32'h55, RD_TIMEOUT + 4, -1, 1); // timeout
    run_op(2'b01, 1'b0, 32'hABCD, 5'd0, 5'd3, 5'd2, 12'hC00, 32'h99, 0, -1, 0);     // read-only addr
    run_op(2'b10, 1'b0, 32'h0, 5'd0, 5'd3, 5'd5, 12'h300, 32'hF0, 0, -1, 0);        // zero value, rs1!=0
    run_op(2'b11, 1'b0, 32'hF, 5'd0, 5'd3, 5'd5, 12'h300, 32'hFF, RD_TIMEOUT - 1, -1, 0); // last-cycle rvalid
    run_op(2'b11, 1'b0, 32'hF, 5'd0, 5'd3, 5'd5, 12'h300, 32'hFF, 2, 2, 0);         // abort with rvalid
    run_op(2'b00, 1'b1, 32'h0, 5'd9, 5'd0, 5'd1, 12'h301, 32'h3C, 0, -1, 0);        // op 00: read only

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      logic [1:0] op; logic imm; logic [4:0] zimm, rs1, rd; int delay, int_at, sel;
      op    = 2'($urandom_range(0, 3));
      imm   = 1'($urandom_range(0, 1));
      zimm  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      sel   = int'($urandom_range(0, 9));
      delay = (sel < 7) ? int'($urandom_range(0, 5)) : (sel == 7) ? RD_TIMEOUT - 1 : RD_TIMEOUT + 2;
      int_at = (delay < RD_TIMEOUT && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, delay)) : -1;
      if (op == 2'b01 && rd == 5'd0) int_at = -1;
      run_op(op, imm, $urandom, zimm, rs1, rd, 12'($urandom), $urandom, delay, int_at,
             int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
